bikelight_multimode: RTL



---
 rtl/bikelight_multimode.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bikelight_multimode.sv
// rtl/bikelight_multimode.sv - debounced push-button bike light cycling OFF/ON/BLINK/DIM
// Optional feature macro: BIKELIGHT_LONGPRESS_EN (holding the button LONG_CYCLES forces OFF)
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset, clears all state
//   btn   - raw asynchronous bouncy button, 1 = pressed
//   led   - LED drive, decoded from registered state
//   mode  - current mode: 0 OFF, 1 ON, 2 BLINK, 3 DIM
module bikelight_multimode #(
    parameter int DEBOUNCE    = 4,
    parameter int BLINK_HALF  = 5000,
    parameter int PWM_BITS    = 4,
    parameter int DIM_DUTY    = 4,
    parameter int LONG_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic       led,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        M_OFF   = 2'd0,
        M_ON    = 2'd1,
        M_BLINK = 2'd2,
        M_DIM   = 2'd3
    } mode_t;

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int BL_W = $clog2(BLINK_HALF + 1);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [BL_W-1:0]   BL_LAST = BL_W'(BLINK_HALF - 1);
    localparam logic [PWM_BITS:0] DUTY    = (PWM_BITS + 1)'(DIM_DUTY);

    if (DEBOUNCE < 1 || BLINK_HALF < 1 || PWM_BITS < 1 || DIM_DUTY < 0 ||
        DIM_DUTY > (1 << PWM_BITS) || LONG_CYCLES < 1) begin : g_param_check
        $error("bikelight_multimode: illegal parameter value");
    end

    logic                sync1_q, sync2_q;
    logic                cond_q, cond_d;
    logic                press_q, press_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    mode_t               mode_q, mode_d;
    logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

`ifdef BIKELIGHT_LONGPRESS_EN
    localparam int HD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HD_W-1:0] HD_MAX  = HD_W'(LONG_CYCLES);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(LONG_CYCLES - 1);
    logic [HD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

    always_comb begin
        // Debounce: count consecutive cycles of disagreement; any agreement clears.
        db_cnt_d = '0;
        cond_d   = cond_q;
        if (sync2_q != cond_q) begin
            if (db_cnt_q == DB_LAST) begin
                cond_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        press_d = cond_d & ~cond_q;

        mode_d = press_q ? mode_t'(mode_q + 2'd1) : mode_q;

`ifdef BIKELIGHT_LONGPRESS_EN
        // Saturating hold counter; the OFF override fires once, on the edge it reaches the limit.
        hold_cnt_d = '0;
        if (cond_q) begin
            hold_cnt_d = hold_cnt_q;
            if (hold_cnt_q != HD_MAX) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
            if (hold_cnt_q == HD_LAST) begin
                mode_d = M_OFF;
            end
        end
`endif

        // Blink: entry starts a full high half-period; idle at 0 outside BLINK.
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
        if (mode_d == M_BLINK) begin
            if (mode_q != M_BLINK) begin
                blink_phase_d = 1'b1;
            end else if (blink_cnt_q == BL_LAST) begin
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 1'b1;
                blink_phase_d = blink_phase_q;
            end
        end

        // PWM counter starts from 0 on DIM entry and wraps naturally.
        pwm_cnt_d = '0;
        if (mode_d == M_DIM && mode_q == M_DIM) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            cond_q        <= 1'b0;
            press_q       <= 1'b0;
            db_cnt_q      <= '0;
            mode_q        <= M_OFF;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pwm_cnt_q     <= '0;
`ifdef BIKELIGHT_LONGPRESS_EN
            hold_cnt_q    <= '0;
`endif
        end else begin
            sync1_q       <= btn;
            sync2_q       <= sync1_q;
            cond_q        <= cond_d;
            press_q       <= press_d;
            db_cnt_q      <= db_cnt_d;
            mode_q        <= mode_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pwm_cnt_q     <= pwm_cnt_d;
`ifdef BIKELIGHT_LONGPRESS_EN
            hold_cnt_q    <= hold_cnt_d;
`endif
        end
    end

    always_comb begin
        led = 1'b0;
        case (mode_q)
            M_OFF:   led = 1'b0;
            M_ON:    led = 1'b1;
            M_BLINK: led = blink_phase_q;
            M_DIM:   led = ({1'b0, pwm_cnt_q} < DUTY);
            default: led = 1'b0;
        endcase
    end

    assign mode = mode_q;

endmodule
